rr_arb4_ctrl: RTL and testbench

- Four-requester round-robin arbiter that shares one 32-bit datapath port between requesters 0..3.
- Computes the 2-bit select for the shared 4:1 mux (a=req0, b=req1, c=req2, d=req3) and registers the selected word into a single-entry output stage.
- Uses valid/ready handshakes on both sides.
- Sits in front of shared resources such as the memory or writeback port.

---
 rtl/rr_arb4_ctrl.sv | 124 ++++++++++++
 tb/tb_rr_arb4_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4_ctrl.sv
// Four-requester round-robin arbiter feeding a single-entry registered output stage.
// The rotating pointer names the requester with top priority and moves only on a grant.
module rr_arb4_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req_valid,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    input  logic [DATA_W-1:0] req_data3,
    output logic [3:0]        req_ready,
    output logic [1:0]        sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    input  logic              out_ready
);

    logic [1:0]        ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_src_q, out_src_d;

    logic [3:0]        rot_valid;
    logic [1:0]        offset;
    logic [1:0]        winner;
    logic              any_req;
    logic              load_en;
    logic [DATA_W-1:0] sel_data;

    assign any_req = |req_valid;
    assign load_en = (!out_valid_q || out_ready) && any_req;

    // rot_valid[k] is requester (ptr + k) mod 4, so a fixed-priority scan implements rotation.
    always_comb begin
        rot_valid = 4'b0000;
        unique case (ptr_q)
            2'd0: rot_valid = req_valid;
            2'd1: rot_valid = {req_valid[0],   req_valid[3:1]};
            2'd2: rot_valid = {req_valid[1:0], req_valid[3:2]};
            2'd3: rot_valid = {req_valid[2:0], req_valid[3]};
        endcase
    end

    always_comb begin
        offset = 2'd0;
        if (rot_valid[0]) begin
            offset = 2'd0;
        end else if (rot_valid[1]) begin
            offset = 2'd1;
        end else if (rot_valid[2]) begin
            offset = 2'd2;
        end else if (rot_valid[3]) begin
            offset = 2'd3;
        end
    end

    // Two-bit addition wraps modulo 4 by construction.
    assign winner = ptr_q + offset;
    assign sel    = any_req ? winner : 2'd0;

    always_comb begin
        req_ready = 4'b0000;
        if (load_en) begin
            unique case (winner)
                2'd0: req_ready = 4'b0001;
                2'd1: req_ready = 4'b0010;
                2'd2: req_ready = 4'b0100;
                2'd3: req_ready = 4'b1000;
            endcase
        end
    end

    always_comb begin
        sel_data = '0;
        unique case (sel)
            2'd0: sel_data = req_data0;
            2'd1: sel_data = req_data1;
            2'd2: sel_data = req_data2;
            2'd3: sel_data = req_data3;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load_en) begin
            ptr_d       = winner + 2'd1;
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = winner;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

    a_hold_on_stall : assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_src));

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Self-checking bench for rr_arb4_ctrl: directed scenarios followed by randomized traffic,
// all compared against a queue-free behavioural model of the arbiter and output register.
module tb_rr_arb4_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [DW-1:0] rd [4];
    logic [3:0]    req_ready;
    logic [1:0]    sel;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic          out_ready;

    rr_arb4_ctrl #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data0 (rd[0]),
        .req_data1 (rd[1]),
        .req_data2 (rd[2]),
        .req_data3 (rd[3]),
        .req_ready (req_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr;
    bit          m_ov;
    logic [31:0] m_od;
    int          m_os;
    int          last_grant;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < 4; k++) begin
            if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_ov  = 1'b0;
        m_od  = '0;
        m_os  = 0;
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle(input logic ordy);
        int  w;
        bit  load;
        logic [3:0] exp_ready;
        out_ready = ordy;
        #1;
        w         = model_winner();
        load      = (!m_ov || ordy) && (w >= 0);
        exp_ready = load ? (4'b0001 << w) : 4'b0000;
        check_eq("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
        check_eq("sel", {30'd0, sel}, (w < 0) ? 32'd0 : w);
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov) begin
            check_eq("out_data", out_data, m_od);
            check_eq("out_src", {30'd0, out_src}, m_os);
        end
        @(posedge clk);
        if (load) begin
            m_od  = rd[w];
            m_os  = w;
            m_ov  = 1'b1;
            m_ptr = (w + 1) % 4;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        last_grant = load ? w : -1;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) rd[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state with no requests
        cycle(1'b0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_out_src", {30'd0, out_src}, 32'd0);

        // Asynchronous reset while a word is held
        for (int i = 0; i < 4; i++) rd[i] = 32'hA000_0000 + i;
        req_valid = 4'b1111;
        cycle(1'b1);
        cycle(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("async_rst_data", out_data, 32'd0);
        check_eq("async_rst_src", {30'd0, out_src}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1);
        check_eq("first_grant_after_rst", last_grant, 32'd0);

        // Round-robin with all four valid
        for (int i = 0; i < 4; i++) rd[i] = 32'h1000_0000 + i;
        repeat (7) cycle(1'b1);

        // Single requester
        req_valid = 4'b0100;
        rd[2]     = 32'hDEAD_BEEF;
        cycle(1'b1);
        req_valid = 4'b0000;
        cycle(1'b1);

        // Backpressure then release
        req_valid = 4'b1111;
        cycle(1'b1);
        repeat (3) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);

        // Pointer wrap and skip
        req_valid = 4'b1000;
        cycle(1'b1);
        req_valid = 4'b1010;
        cycle(1'b1);
        check_eq("skip_grant1", last_grant, 32'd1);
        cycle(1'b1);
        check_eq("wrap_grant3", last_grant, 32'd3);
        cycle(1'b1);
        check_eq("wrap_grant1", last_grant, 32'd1);

        // Idle drain
        req_valid = 4'b0001;
        cycle(1'b1);
        req_valid = 4'b0000;
        cycle(1'b1);
        cycle(1'b1);

        // Randomized traffic; requesters hold valid/data until granted
        for (int n = 0; n < 2000; n++) begin
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    req_valid[i] = 1'b1;
                    rd[i]        = $urandom;
                end
            end
            cycle($urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
